// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: FSM encoding, default
// widths, counter limits and forwarding-bus slice offsets.
package id_operand_stage_pkg;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_INTERLOCK = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam int          CNT_W   = 32;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Bit offset of source idx inside a flattened per-source bus of elem_w bits.
  function automatic int fwd_off(input int idx, input int elem_w);
    return idx * elem_w;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Per-operand bypass selector. The lowest-index (youngest) enabled source
// whose destination matches wins, even when its result is still pending;
// register 0 always reads as zero and never raises a hazard.
module fwd_select
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic                      used,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic [DATA_W-1:0]         value,
  output logic                      hazard
);

  logic              hit;
  logic              hit_i;
  logic              pend;
  logic [DATA_W-1:0] sel;

  // Scan oldest to youngest so the youngest matching source is applied last.
  always_comb begin
    hit   = 1'b0;
    hit_i = 1'b0;
    pend  = 1'b0;
    sel   = rf_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      hit_i = fwd_we[i] && (fwd_waddr[fwd_off(i, REG_AW) +: REG_AW] == addr);
      sel   = hit_i ? fwd_wdata[fwd_off(i, DATA_W) +: DATA_W] : sel;
      pend  = hit_i ? fwd_pending[i] : pend;
      hit   = hit | hit_i;
    end
    if (addr == {REG_AW{1'b0}}) begin
      value  = {DATA_W{1'b0}};
      hazard = 1'b0;
    end else begin
      value  = sel;
      hazard = used & hit & pend;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID/EX boundary stage: resolves rs/rt through the forwarding buses, raises
// a load-use interlock, and owns the ID/EX register (hold, bubble, flush).
// Optional build macro ID_STALL_CNT_EN adds stall_cycles/bubble_cnt counters.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int NUM_FWD   = 3,
  parameter int PAYLOAD_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      ex_stall,
  input  logic                      in_valid,
  input  logic [31:0]               in_pc,
  input  logic [PAYLOAD_W-1:0]      in_payload,
  input  logic [REG_AW-1:0]         in_rs_addr,
  input  logic [REG_AW-1:0]         in_rt_addr,
  input  logic                      in_rs_used,
  input  logic                      in_rt_used,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  output logic                      in_ready,
  output logic                      stallreq,
  output logic                      interlock,
  output logic                      out_valid,
  output logic [31:0]               out_pc,
  output logic [PAYLOAD_W-1:0]      out_payload,
  output logic [DATA_W-1:0]         out_rs_val,
  output logic [DATA_W-1:0]         out_rt_val
`ifdef ID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          bubble_cnt
`endif
);

  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              rs_hazard;
  logic              rt_hazard;
  logic              hazard;
  state_t            state;
  state_t            state_nxt;

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs_sel (
    .addr        (in_rs_addr),
    .used        (in_rs_used),
    .rf_data     (rf_rdata1),
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_pending (fwd_pending),
    .value       (rs_val),
    .hazard      (rs_hazard)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rt_sel (
    .addr        (in_rt_addr),
    .used        (in_rt_used),
    .rf_data     (rf_rdata2),
    .fwd_we      (fwd_we),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .fwd_pending (fwd_pending),
    .value       (rt_val),
    .hazard      (rt_hazard)
  );

  assign hazard    = in_valid & (rs_hazard | rt_hazard);
  assign stallreq  = hazard & ~flush;
  assign in_ready  = ~ex_stall & ~hazard;
  assign interlock = (state == ST_INTERLOCK);

  // Interlock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Interlock FSM next state: flush always returns to RUN, ex_stall freezes INTERLOCK.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (hazard && !flush && !ex_stall) begin
          state_nxt = ST_INTERLOCK;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_INTERLOCK: begin
        if (flush) begin
          state_nxt = ST_RUN;
        end else if (ex_stall) begin
          state_nxt = ST_INTERLOCK;
        end else if (!hazard) begin
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_INTERLOCK;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // ID/EX register: flush, then hold, then hazard bubble, then capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'h0000_0000;
      out_payload <= {PAYLOAD_W{1'b0}};
      out_rs_val  <= {DATA_W{1'b0}};
      out_rt_val  <= {DATA_W{1'b0}};
    end else if (flush || (!ex_stall && (hazard || !in_valid))) begin
      out_valid   <= 1'b0;
      out_pc      <= 32'h0000_0000;
      out_payload <= {PAYLOAD_W{1'b0}};
      out_rs_val  <= {DATA_W{1'b0}};
      out_rt_val  <= {DATA_W{1'b0}};
    end else if (!ex_stall) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_payload <= in_payload;
      out_rs_val  <= rs_val;
      out_rt_val  <= rt_val;
    end else begin
      out_valid   <= out_valid;
      out_pc      <= out_pc;
      out_payload <= out_payload;
      out_rs_val  <= out_rs_val;
      out_rt_val  <= out_rt_val;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic bubble_evt;
  assign bubble_evt = flush | (~ex_stall & hazard);

  // Saturating count of cycles spent in INTERLOCK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= {CNT_W{1'b0}};
    end else if ((state == ST_INTERLOCK) && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

  // Saturating count of bubbles inserted by flush or load-use hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= {CNT_W{1'b0}};
    end else if (bubble_evt && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end else begin
      bubble_cnt <= bubble_cnt;
    end
  end
`else
  // Counter build option disabled: no counter ports or state.
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// behavioural model.
module tb_id_operand_stage;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int NUM_FWD   = 3;
  localparam int PAYLOAD_W = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush, ex_stall, in_valid;
  logic [31:0]               in_pc;
  logic [PAYLOAD_W-1:0]      in_payload;
  logic [REG_AW-1:0]         in_rs_addr, in_rt_addr;
  logic                      in_rs_used, in_rt_used;
  logic [DATA_W-1:0]         rf_rdata1, rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_we, fwd_pending;
  logic [NUM_FWD*REG_AW-1:0] fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic                      in_ready, stallreq, interlock, out_valid;
  logic [31:0]               out_pc;
  logic [PAYLOAD_W-1:0]      out_payload;
  logic [DATA_W-1:0]         out_rs_val, out_rt_val;
`ifdef ID_STALL_CNT_EN
  logic [31:0]               stall_cycles, bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // model state
  logic                 m_valid;
  logic [31:0]          m_pc;
  logic [PAYLOAD_W-1:0] m_pay;
  logic [DATA_W-1:0]    m_rs, m_rt;
  logic                 m_il;
  logic [31:0]          m_sc, m_bc;

  id_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall), .in_valid(in_valid),
    .in_pc(in_pc), .in_payload(in_payload), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_used(in_rs_used), .in_rt_used(in_rt_used), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_pending(fwd_pending),
    .in_ready(in_ready), .stallreq(stallreq), .interlock(interlock), .out_valid(out_valid),
    .out_pc(out_pc), .out_payload(out_payload), .out_rs_val(out_rs_val), .out_rt_val(out_rt_val)
`ifdef ID_STALL_CNT_EN
    , .stall_cycles(stall_cycles), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs, rt;
    logic        rsu, rtu;
    logic [31:0] rf1, rf2;
    logic [2:0]  we;
    logic [14:0] waddr;
    logic [95:0] wdata;
    logic [2:0]  pend;
    logic        e_stall, e_valid;
    logic [31:0] e_rs, e_rt;
  } vec_t;

  vec_t vt[7];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic rsu, input logic rtu,
                              input logic [31:0] rf1, input logic [31:0] rf2, input logic [2:0] we,
                              input logic [14:0] waddr, input logic [95:0] wdata, input logic [2:0] pend,
                              input logic e_stall, input logic e_valid, input logic [31:0] e_rs,
                              input logic [31:0] e_rt);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rsu = rsu; v.rtu = rtu; v.rf1 = rf1; v.rf2 = rf2;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.pend = pend;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference rule: r0 reads zero; else first enabled matching source by
  // ascending index; else regfile. Returns {hazard, value}.
  function automatic logic [DATA_W:0] resolve(input logic [REG_AW-1:0] a, input logic used,
                                               input logic [DATA_W-1:0] rf);
    if (a == 5'd0) return {1'b0, 32'd0};
    for (int i = 0; i < NUM_FWD; i++) begin
      if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == a)
        return {used & fwd_pending[i], fwd_wdata[i*DATA_W +: DATA_W]};
    end
    return {1'b0, rf};
  endfunction

  task automatic reset_model();
    m_valid = 1'b0; m_pc = 32'd0; m_pay = 64'd0; m_rs = 32'd0; m_rt = 32'd0;
    m_il = 1'b0; m_sc = 32'd0; m_bc = 32'd0;
  endtask

  task automatic clear_fwd();
    fwd_we = 3'b000; fwd_pending = 3'b000; fwd_waddr = 15'd0; fwd_wdata = 96'd0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic rsu, input logic rtu,
                       input logic [31:0] rf1, input logic [31:0] rf2);
    in_valid = 1'b1; in_rs_addr = rs; in_rt_addr = rt; in_rs_used = rsu; in_rt_used = rtu;
    rf_rdata1 = rf1; rf_rdata2 = rf2;
    in_pc = $urandom; in_payload = {$urandom, $urandom};
  endtask

  // One clock with current inputs: check combinational outputs, advance model, check registers.
  task automatic cycle();
    logic [DATA_W:0] rs, rt;
    logic hz;
    #1;
    rs = resolve(in_rs_addr, in_rs_used, rf_rdata1);
    rt = resolve(in_rt_addr, in_rt_used, rf_rdata2);
    hz = in_valid & (rs[DATA_W] | rt[DATA_W]);
    chk("stallreq", {63'd0, stallreq}, {63'd0, hz & !flush});
    chk("in_ready", {63'd0, in_ready}, {63'd0, !ex_stall & !hz});
    if (m_il && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
    if ((flush || (!ex_stall && hz)) && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 32'd1;
    if (flush || (!ex_stall && (hz || !in_valid))) begin
      m_valid = 1'b0; m_pc = 32'd0; m_pay = 64'd0; m_rs = 32'd0; m_rt = 32'd0;
    end else if (!ex_stall) begin
      m_valid = 1'b1; m_pc = in_pc; m_pay = in_payload; m_rs = rs[DATA_W-1:0]; m_rt = rt[DATA_W-1:0];
    end
    if (m_il) m_il = !flush && (ex_stall || hz);
    else      m_il = hz && !flush && !ex_stall;
    @(posedge clk);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("out_pc", {32'd0, out_pc}, {32'd0, m_pc});
    chk("out_payload", out_payload, m_pay);
    chk("out_rs_val", {32'd0, out_rs_val}, {32'd0, m_rs});
    chk("out_rt_val", {32'd0, out_rt_val}, {32'd0, m_rt});
    chk("interlock", {63'd0, interlock}, {63'd0, m_il});
`ifdef ID_STALL_CNT_EN
    chk("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_sc});
    chk("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, m_bc});
`endif
  endtask

  initial begin
    vt[0] = mk(5'd5, 5'd6, 1'b1, 1'b1, 32'hAAAA_0001, 32'hBBBB_0002, 3'b101, {5'd5, 5'd0, 5'd5},
               {32'h2222_2222, 32'd0, 32'h1111_1111}, 3'b000, 1'b0, 1'b1, 32'h1111_1111, 32'hBBBB_0002);
    vt[1] = mk(5'd3, 5'd0, 1'b1, 1'b1, 32'hAAAA_0003, 32'h1234_5678, 3'b001, 15'd0,
               {64'd0, 32'hDEAD_BEEF}, 3'b000, 1'b0, 1'b1, 32'hAAAA_0003, 32'd0);
    vt[2] = mk(5'd7, 5'd1, 1'b1, 1'b1, 32'hAAAA_0007, 32'hBBBB_0007, 3'b101, {5'd7, 5'd0, 5'd7},
               {32'h3333_3333, 32'd0, 32'h4444_4444}, 3'b001, 1'b1, 1'b0, 32'd0, 32'd0);
    vt[3] = mk(5'd2, 5'd7, 1'b1, 1'b0, 32'hAAAA_0004, 32'hBBBB_0004, 3'b001, {10'd0, 5'd7},
               {64'd0, 32'h5555_5555}, 3'b001, 1'b0, 1'b1, 32'hAAAA_0004, 32'h5555_5555);
    vt[4] = mk(5'd4, 5'd4, 1'b1, 1'b1, 32'hAAAA_0008, 32'hBBBB_0008, 3'b010, {5'd0, 5'd4, 5'd0},
               {32'd0, 32'h0BAD_F00D, 32'd0}, 3'b100, 1'b0, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D);
    vt[5] = mk(5'd1, 5'd9, 1'b1, 1'b1, 32'hAAAA_0005, 32'hBBBB_0005, 3'b110, {5'd9, 5'd9, 5'd0},
               {32'h6666_6666, 32'h7777_7777, 32'd0}, 3'b010, 1'b1, 1'b0, 32'd0, 32'd0);
    vt[6] = mk(5'd0, 5'd1, 1'b1, 1'b1, 32'hAAAA_0006, 32'hBBBB_0006, 3'b001, 15'd0,
               {64'd0, 32'h8888_8888}, 3'b001, 1'b0, 1'b1, 32'd0, 32'hBBBB_0006);

    rst = 1'b1; flush = 1'b0; ex_stall = 1'b0; in_valid = 1'b0;
    in_pc = 32'd0; in_payload = 64'd0; in_rs_addr = 5'd0; in_rt_addr = 5'd0;
    in_rs_used = 1'b0; in_rt_used = 1'b0; rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
    clear_fwd();
    reset_model();
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_interlock", {63'd0, interlock}, 64'd0);
    chk("reset_out_rs_val", {32'd0, out_rs_val}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      flush = 1'b0; ex_stall = 1'b0;
      drive(vt[i].rs, vt[i].rt, vt[i].rsu, vt[i].rtu, vt[i].rf1, vt[i].rf2);
      fwd_we = vt[i].we; fwd_waddr = vt[i].waddr; fwd_wdata = vt[i].wdata; fwd_pending = vt[i].pend;
      #1;
      chk($sformatf("vec%0d_stallreq", i), {63'd0, stallreq}, {63'd0, vt[i].e_stall});
      cycle();
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_valid});
      chk($sformatf("vec%0d_rs", i), {32'd0, out_rs_val}, {32'd0, vt[i].e_rs});
      chk($sformatf("vec%0d_rt", i), {32'd0, out_rt_val}, {32'd0, vt[i].e_rt});
    end

    // load-use: EX pending for one cycle, then MEM supplies the value
    clear_fwd();
    in_valid = 1'b0;
    cycle();
    drive(5'd8, 5'd0, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'd0);
    fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd8}; fwd_wdata = {64'd0, 32'h0000_0099}; fwd_pending = 3'b001;
    #1;
    chk("lu_stallreq", {63'd0, stallreq}, 64'd1);
    chk("lu_in_ready", {63'd0, in_ready}, 64'd0);
    cycle();
    chk("lu_interlock", {63'd0, interlock}, 64'd1);
    chk("lu_bubble", {63'd0, out_valid}, 64'd0);
    fwd_we = 3'b010; fwd_waddr = {5'd0, 5'd8, 5'd0}; fwd_wdata = {32'd0, 32'h0000_00AB, 32'd0}; fwd_pending = 3'b000;
    cycle();
    chk("lu_capture_valid", {63'd0, out_valid}, 64'd1);
    chk("lu_capture_rs", {32'd0, out_rs_val}, 64'h0000_00AB);
    chk("lu_run", {63'd0, interlock}, 64'd0);

    // flush versus hazard while interlocked
    fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd8}; fwd_wdata = 96'd0; fwd_pending = 3'b001;
    cycle();
    chk("fh_enter_il", {63'd0, interlock}, 64'd1);
    flush = 1'b1;
    #1;
    chk("fh_stallreq", {63'd0, stallreq}, 64'd0);
    cycle();
    chk("fh_valid", {63'd0, out_valid}, 64'd0);
    chk("fh_run", {63'd0, interlock}, 64'd0);
    flush = 1'b0;

    // hold: WB writes the held rs register during a 3-cycle ex_stall
    clear_fwd();
    drive(5'd9, 5'd3, 1'b1, 1'b1, 32'h0000_0909, 32'h0000_0303);
    cycle();
    ex_stall = 1'b1;
    fwd_we = 3'b100; fwd_waddr = {5'd9, 10'd0}; fwd_wdata = {32'hFFFF_0000, 64'd0};
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_rs", {32'd0, out_rs_val}, 64'h0000_0909);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
    end
    ex_stall = 1'b0;
    clear_fwd();
    in_valid = 1'b0;

    // asynchronous reset with a valid instruction held
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_rs", {32'd0, out_rs_val}, 64'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset mid-interlock
    drive(5'd8, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0);
    fwd_we = 3'b001; fwd_waddr = {10'd0, 5'd8}; fwd_pending = 3'b001;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_il_interlock", {63'd0, interlock}, 64'd0);
    chk("arst_il_valid", {63'd0, out_valid}, 64'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 4) == 0);
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, $urandom);
      in_valid = ($urandom_range(0, 7) != 0);
      fwd_we = 3'($urandom);
      fwd_pending = 3'($urandom) & 3'($urandom);
      for (int j = 0; j < NUM_FWD; j++) begin
        fwd_waddr[j*REG_AW +: REG_AW] = 5'($urandom_range(0, 7));
        fwd_wdata[j*DATA_W +: DATA_W] = $urandom;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
